fifo_r_stream: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 12 +
 rtl/fifo_r_stream.sv | 84 ++++++++
 tb/tb_fifo_r_stream.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types for the async FIFO and its read-side stream adapter.
package async_fifo_pkg;

    // Default payload carried through the FIFO and the output stream.
    typedef logic [7:0] data_t;

    // Occupancy of the 2-entry read-side output buffer (0..2).
    typedef logic [1:0] cnt_t;

    localparam cnt_t BUF_DEPTH = 2'd2;

endpackage : async_fifo_pkg

// File: rtl/fifo_r_stream.sv
// Read-side consumer of the async FIFO: turns the pop interface into a
// registered valid/ready stream through a 2-entry skid buffer. The pop
// strobe depends only on buffer state and the FIFO empty flag, so the
// downstream ready never reaches the FIFO combinationally.
module fifo_r_stream #(
    parameter type data_t = async_fifo_pkg::data_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  flush_i,
    input  data_t r_data_i,
    input  logic  r_empty_i,
    output logic  r_en_o,
    output data_t data_o,
    output logic  valid_o,
    input  logic  ready_i,
    output logic  [1:0] count_o
);

    import async_fifo_pkg::*;

    data_t slot_q [2];
    logic  hd_q;
    logic  tl_q;
    cnt_t  count_q;
    cnt_t  count_d;
    logic  pop;
    logic  out;

    // Pop/accept handshakes; reset and flush both suppress the pop so no
    // FIFO word is consumed while the buffer is being cleared.
    always_comb begin
        pop = rst_ni && !flush_i && !r_empty_i && (count_q != BUF_DEPTH);
        out = valid_o && ready_i;
    end

    // Occupancy update: a simultaneous pop and accept leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({pop, out})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers and count; reset and flush return to empty.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            count_q <= '0;
            hd_q    <= 1'b0;
            tl_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pop) tl_q <= ~tl_q;
            if (out) hd_q <= ~hd_q;
        end
    end

    // Payload storage: written on pop, never reset (only valid slots are read).
    always_ff @(posedge clk_i) begin
        if (pop) slot_q[tl_q] <= r_data_i;
    end

    // Stream outputs are decoded straight from registered state.
    always_comb begin
        r_en_o  = pop;
        valid_o = (count_q != '0);
        data_o  = slot_q[hd_q];
        count_o = count_q;
    end

`ifndef SYNTHESIS
    a_count_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= BUF_DEPTH);

    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(r_en_o && r_empty_i));

    a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o)));
`endif

endmodule : fifo_r_stream

// File: tb/tb_fifo_r_stream.sv
// Directed and randomized bench for fifo_r_stream with a queue-based FIFO model.
module tb_fifo_r_stream;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       flush_i = 1'b0;
    logic [7:0] r_data_i = 8'h00;
    logic       r_empty_i = 1'b1;
    logic       r_en_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic [1:0] count_o;

    fifo_r_stream dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .r_data_i (r_data_i),
        .r_empty_i(r_empty_i),
        .r_en_o   (r_en_o),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .count_o  (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       fl;
        logic       rdy;
        logic       fe;
        logic       ren;
        logic       vld;
        logic [7:0] dat;
        logic [1:0] cnt;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] src[$];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       s_ren, s_valid, s_empty, s_rdy;
    logic [7:0] s_data;
    logic [1:0] s_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample outputs, then pop the model at posedge.
    task automatic cyc(input logic rst, input logic fl, input logic rdy, input logic fe);
        @(negedge clk);
        rst_ni    = rst;
        flush_i   = fl;
        ready_i   = rdy;
        r_empty_i = fe || (src.size() == 0);
        r_data_i  = (src.size() != 0) ? src[0] : 8'h00;
        #1;
        s_ren   = r_en_o;
        s_valid = valid_o;
        s_data  = data_o;
        s_cnt   = count_o;
        s_empty = r_empty_i;
        s_rdy   = rdy;
        @(posedge clk);
        if (s_ren && src.size() != 0) void'(src.pop_front());
    endtask

    function automatic void add(input logic rst, input logic fl, input logic rdy,
                                input logic fe, input logic ren, input logic vld,
                                input logic [7:0] dat, input logic [1:0] cnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.rdy = rdy; v.fe = fe;
        v.ren = ren; v.vld = vld; v.dat = dat; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].fl, tbl[i].rdy, tbl[i].fe);
            chk($sformatf("%s[%0d].r_en", nm, i), s_ren, tbl[i].ren);
            chk($sformatf("%s[%0d].valid", nm, i), s_valid, tbl[i].vld);
            chk($sformatf("%s[%0d].count", nm, i), s_cnt, tbl[i].cnt);
            if (tbl[i].vld)
                chk($sformatf("%s[%0d].data", nm, i), s_data, tbl[i].dat);
        end
        tbl.delete();
    endtask

    initial begin
        // Reset with a non-empty FIFO, then stream 0x10..0x17 at full rate.
        for (int i = 0; i < 8; i++) src.push_back(8'h10 + 8'(i));
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset0.r_en", s_ren, 0);
        add(0, 0, 1, 0, 0, 0, 8'h00, 2'd0);
        add(1, 0, 1, 0, 1, 0, 8'h00, 2'd0);
        for (int i = 0; i < 7; i++) add(1, 0, 1, 0, 1, 1, 8'h10 + 8'(i), 2'd1);
        add(1, 0, 1, 0, 0, 1, 8'h17, 2'd1);
        add(1, 0, 1, 0, 0, 0, 8'h00, 2'd0);
        run_tbl("stream");

        // Stall for 5 cycles with 0xA0..0xA5 available, then release.
        for (int i = 0; i < 6; i++) src.push_back(8'hA0 + 8'(i));
        add(1, 0, 0, 0, 1, 0, 8'h00, 2'd0);
        add(1, 0, 0, 0, 1, 1, 8'hA0, 2'd1);
        add(1, 0, 0, 0, 0, 1, 8'hA0, 2'd2);
        add(1, 0, 0, 0, 0, 1, 8'hA0, 2'd2);
        add(1, 0, 0, 0, 0, 1, 8'hA0, 2'd2);
        add(1, 0, 1, 0, 0, 1, 8'hA0, 2'd2);
        add(1, 0, 1, 0, 1, 1, 8'hA1, 2'd1);
        add(1, 0, 1, 0, 1, 1, 8'hA2, 2'd1);
        add(1, 0, 1, 0, 1, 1, 8'hA3, 2'd1);
        add(1, 0, 1, 0, 1, 1, 8'hA4, 2'd1);
        add(1, 0, 1, 0, 0, 1, 8'hA5, 2'd1);
        add(1, 0, 1, 0, 0, 0, 8'h00, 2'd0);
        run_tbl("stall");

        // Single word: one pop, one output, empty flag blocks further pops.
        src.push_back(8'h55);
        cyc(1, 0, 1, 0);
        chk("empty.pop", s_ren, 1);
        cyc(1, 0, 1, 0);
        chk("empty.r_en_after", s_ren, 0);
        chk("empty.valid", s_valid, 1);
        chk("empty.data", s_data, 8'h55);
        cyc(1, 0, 1, 0);
        chk("empty.valid_drop", s_valid, 0);
        chk("empty.r_en_idle", s_ren, 0);

        // Flush a full buffer (0x01/0x02); the FIFO head 0x03 must follow.
        for (int i = 1; i <= 4; i++) src.push_back(8'(i));
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("flush.pre_count", s_cnt, 2);
        chk("flush.pre_data", s_data, 8'h01);
        cyc(1, 1, 1, 0);
        chk("flush.r_en", s_ren, 0);
        cyc(1, 0, 1, 0);
        chk("flush.valid_next", s_valid, 0);
        chk("flush.count_next", s_cnt, 0);
        chk("flush.repop", s_ren, 1);
        cyc(1, 0, 1, 0);
        chk("flush.head", s_data, 8'h03);
        chk("flush.head_valid", s_valid, 1);
        cyc(1, 0, 1, 0);
        chk("flush.next", s_data, 8'h04);
        cyc(1, 0, 1, 0);
        chk("flush.drained", s_valid, 0);

        // Mid-stream reset clears the buffer without losing FIFO words.
        src.push_back(8'h61); src.push_back(8'h62); src.push_back(8'h63);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("mreset.r_en", s_ren, 0);
        cyc(1, 0, 1, 0);
        chk("mreset.valid", s_valid, 0);
        cyc(1, 0, 1, 0);
        chk("mreset.data", s_data, 8'h62);
        cyc(1, 0, 1, 0);
        chk("mreset.data2", s_data, 8'h63);
        cyc(1, 0, 1, 0);

        // Random ready and empty flag against an in-order scoreboard.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] w;
            w = 8'($urandom_range(0, 255));
            src.push_back(w);
            exp_q.push_back(w);
        end
        begin
            logic       p_valid = 1'b0, p_rdy = 1'b0;
            logic [7:0] p_data = 8'h00;
            int         budget = 20000;
            while (exp_q.size() != 0 && budget > 0) begin
                budget--;
                cyc(1, 0, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
                if (s_ren && s_empty) chk("rand.pop_empty", 1, 0);
                if (s_cnt > 2'd2) chk("rand.count", s_cnt, 2);
                if (p_valid && !p_rdy) begin
                    if (!s_valid) chk("rand.stall_valid", s_valid, 1);
                    else if (s_data != p_data) chk("rand.stall_data", s_data, p_data);
                end
                if (s_valid && s_rdy) begin
                    if (exp_q.size() != 0) chk("rand.data", s_data, exp_q.pop_front());
                    else chk("rand.extra_word", 1, 0);
                end
                p_valid = s_valid; p_rdy = s_rdy; p_data = s_data;
            end
            if (budget == 0) chk("rand.timeout_words_left", exp_q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fifo_r_stream
